// File: rtl/median_kernel_scheduler_pkg.sv
// Shared definitions for the median kernel scheduler.
//   state_t     : scheduler FSM states (IDLE, ROW, COL, DIAG, OUT)
//   window_t    : 5x5 pixel window [row][col] at the default 8-bit width;
//                 modules with a different DATA_WIDTH declare a local
//                 equivalent of the same shape
//   KERNEL_DIM  : window side length
//   DIAG_ROW/COL: anti-diagonal coordinates, lower-left to upper-right
package median_kernel_scheduler_pkg;

  localparam int unsigned KERNEL_DIM = 5;
  localparam int unsigned PIX_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    DIAG,
    OUT
  } state_t;

  typedef logic [0:KERNEL_DIM-1][0:KERNEL_DIM-1][PIX_W-1:0] window_t;

  localparam int unsigned DIAG_ROW [KERNEL_DIM] = '{4, 3, 2, 1, 0};
  localparam int unsigned DIAG_COL [KERNEL_DIM] = '{0, 1, 2, 3, 4};

endpackage

// File: rtl/ranging_kernel.sv
// Line-sorting kernel: sorts each of the five 5-element lines of a window
// in ascending order and presents the result SORT_LATENCY cycles later.
//   i_clk, i_aresetn : clock, asynchronous active-low reset
//   i_lines          : five lines to sort, [line][element]
//   o_lines          : sorted lines, delayed by SORT_LATENCY cycles
// SORT_BY_COLUMN=1 treats the columns of i_lines as the lines instead.
module ranging_kernel
  import median_kernel_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SORT_LATENCY   = 3,
  parameter bit          SORT_BY_COLUMN = 1'b0
) (
  input  logic                                                 i_clk,
  input  logic                                                 i_aresetn,
  input  logic [0:KERNEL_DIM-1][0:KERNEL_DIM-1][DATA_WIDTH-1:0] i_lines,
  output logic [0:KERNEL_DIM-1][0:KERNEL_DIM-1][DATA_WIDTH-1:0] o_lines
);

  typedef logic [0:KERNEL_DIM-1][0:KERNEL_DIM-1][DATA_WIDTH-1:0] win_t;

  function automatic win_t transpose(input win_t w);
    win_t t;
    for (int unsigned r = 0; r < KERNEL_DIM; r++)
      for (int unsigned c = 0; c < KERNEL_DIM; c++)
        t[c][r] = w[r][c];
    return t;
  endfunction

  win_t lines_in;
  win_t sorted;
  win_t pipe [SORT_LATENCY];

  assign lines_in = SORT_BY_COLUMN ? transpose(i_lines) : i_lines;

  always_comb begin
    logic [DATA_WIDTH-1:0] tmp;
    tmp    = '0;
    sorted = lines_in;
    for (int unsigned l = 0; l < KERNEL_DIM; l++)
      for (int unsigned p = 0; p < KERNEL_DIM - 1; p++)
        for (int unsigned j = 0; j < KERNEL_DIM - 1 - p; j++)
          if (sorted[l][j] > sorted[l][j+1]) begin
            tmp            = sorted[l][j];
            sorted[l][j]   = sorted[l][j+1];
            sorted[l][j+1] = tmp;
          end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      for (int unsigned i = 0; i < SORT_LATENCY; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= sorted;
      for (int unsigned i = 1; i < SORT_LATENCY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign o_lines = SORT_BY_COLUMN ? transpose(pipe[SORT_LATENCY-1])
                                  : pipe[SORT_LATENCY-1];

endmodule

// File: rtl/median_kernel_scheduler.sv
// Approximate 5x5 median: row sort, column sort, then the median of the
// sorted anti-diagonal, time-sharing one ranging_kernel across three passes.
//   i_clk, i_aresetn               : clock, asynchronous active-low reset
//   i_window / i_window_valid      : input window [row][col] and its valid
//   o_window_ready                 : window accepted this cycle
//   o_median / o_median_valid      : result and its valid
//   i_median_ready                 : downstream accepts the result
//   o_busy                         : scheduler not idle
// Optional (macro MEDIAN_KERNEL_SCHEDULER_PERF_CNT_EN):
//   o_perf_windows                 : completed OUT handshakes (wrapping)
//   o_perf_stall                   : OUT cycles with i_median_ready low
module median_kernel_scheduler
  import median_kernel_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned KERNEL_SIZE  = 5,
  parameter int unsigned SORT_LATENCY = 3
) (
  input  logic                                                 i_clk,
  input  logic                                                 i_aresetn,
  input  logic [0:KERNEL_DIM-1][0:KERNEL_DIM-1][DATA_WIDTH-1:0] i_window,
  input  logic                                                 i_window_valid,
  output logic                                                 o_window_ready,
  output logic [DATA_WIDTH-1:0]                                o_median,
  output logic                                                 o_median_valid,
  input  logic                                                 i_median_ready,
  output logic                                                 o_busy
`ifdef MEDIAN_KERNEL_SCHEDULER_PERF_CNT_EN
  ,
  output logic [31:0]                                          o_perf_windows,
  output logic [31:0]                                          o_perf_stall
`endif
);

  if (KERNEL_SIZE != KERNEL_DIM) begin : g_bad_kernel_size
    $error("median_kernel_scheduler: KERNEL_SIZE must be 5");
  end
  if (SORT_LATENCY < 1 || SORT_LATENCY > 15) begin : g_bad_sort_latency
    $error("median_kernel_scheduler: SORT_LATENCY must be 1..15");
  end

  typedef logic [0:KERNEL_DIM-1][0:KERNEL_DIM-1][DATA_WIDTH-1:0] win_t;

  function automatic win_t transpose(input win_t w);
    win_t t;
    for (int unsigned r = 0; r < KERNEL_DIM; r++)
      for (int unsigned c = 0; c < KERNEL_DIM; c++)
        t[c][r] = w[r][c];
    return t;
  endfunction

  state_t     state;
  state_t     state_nxt;
  logic [3:0] pass_cnt;
  logic       pass_done;
  logic       accept;
  logic       cooldown;
  win_t       work;
  win_t       sort_in;
  win_t       sort_out;

  assign pass_done = (pass_cnt == 4'(SORT_LATENCY));

  // Ready is additionally held low for the single IDLE cycle that follows an
  // OUT handshake, so consecutive windows are always separated by one idle.
  always_comb begin
    state_nxt      = state;
    o_window_ready = (state == IDLE) && !cooldown;
    accept         = o_window_ready && i_window_valid;
    o_median_valid = (state == OUT);
    o_busy         = (state != IDLE);
    case (state)
      IDLE:    if (accept)         state_nxt = ROW;
      ROW:     if (pass_done)      state_nxt = COL;
      COL:     if (pass_done)      state_nxt = DIAG;
      DIAG:    if (pass_done)      state_nxt = OUT;
      OUT:     if (i_median_ready) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state    <= IDLE;
      pass_cnt <= '0;
      cooldown <= 1'b0;
    end else begin
      state    <= state_nxt;
      cooldown <= (state == OUT) && i_median_ready;
      if (state_nxt != state || state == IDLE || state == OUT)
        pass_cnt <= '0;
      else
        pass_cnt <= pass_cnt + 4'd1;
    end
  end

  // Sorter input depends only on state and the working register, which are
  // both constant for the whole pass.
  always_comb begin
    sort_in = '0;
    case (state)
      ROW:  sort_in = work;
      COL:  sort_in = transpose(work);
      DIAG: begin
        for (int unsigned k = 0; k < KERNEL_DIM; k++)
          sort_in[0][k] = work[DIAG_ROW[k]][DIAG_COL[k]];
      end
      default: sort_in = '0;
    endcase
  end

  ranging_kernel #(
    .DATA_WIDTH     (DATA_WIDTH),
    .SORT_LATENCY   (SORT_LATENCY),
    .SORT_BY_COLUMN (1'b0)
  ) u_ranging_kernel (
    .i_clk     (i_clk),
    .i_aresetn (i_aresetn),
    .i_lines   (sort_in),
    .o_lines   (sort_out)
  );

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      work     <= '0;
      o_median <= '0;
    end else begin
      case (state)
        IDLE: if (accept)    work     <= i_window;
        ROW:  if (pass_done) work     <= sort_out;
        COL:  if (pass_done) work     <= transpose(sort_out);
        DIAG: if (pass_done) o_median <= sort_out[0][2];
        default: ;
      endcase
    end
  end

`ifdef MEDIAN_KERNEL_SCHEDULER_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_perf_windows <= '0;
      o_perf_stall   <= '0;
    end else if (state == OUT) begin
      if (i_median_ready) o_perf_windows <= o_perf_windows + 32'd1;
      else                o_perf_stall   <= o_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_median_kernel_scheduler.sv
module tb_median_kernel_scheduler;
  import median_kernel_scheduler_pkg::*;

  localparam int unsigned SL     = 3;
  localparam int unsigned LAT    = 3 * (SL + 1) + 1;
  localparam int unsigned PERIOD = LAT + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  window_t    win = '0;
  logic       win_valid = 1'b0;
  logic       win_ready;
  logic [7:0] med;
  logic       med_valid;
  logic       med_ready = 1'b1;
  logic       busy;
`ifdef MEDIAN_KERNEL_SCHEDULER_PERF_CNT_EN
  logic [31:0] perf_windows;
  logic [31:0] perf_stall;
`endif

  median_kernel_scheduler #(
    .DATA_WIDTH   (8),
    .KERNEL_SIZE  (5),
    .SORT_LATENCY (SL)
  ) dut (
    .i_clk          (clk),
    .i_aresetn      (rst_n),
    .i_window       (win),
    .i_window_valid (win_valid),
    .o_window_ready (win_ready),
    .o_median       (med),
    .o_median_valid (med_valid),
    .i_median_ready (med_ready),
    .o_busy         (busy)
`ifdef MEDIAN_KERNEL_SCHEDULER_PERF_CNT_EN
    ,
    .o_perf_windows (perf_windows),
    .o_perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: sort rows, sort columns, take the middle of the anti-diagonal.
  function automatic logic [7:0] ref_median(input window_t w);
    int m [5][5];
    int q [$];
    for (int r = 0; r < 5; r++) begin
      q.delete();
      for (int c = 0; c < 5; c++) q.push_back(int'(w[r][c]));
      q.sort();
      for (int c = 0; c < 5; c++) m[r][c] = q[c];
    end
    for (int c = 0; c < 5; c++) begin
      q.delete();
      for (int r = 0; r < 5; r++) q.push_back(m[r][c]);
      q.sort();
      for (int r = 0; r < 5; r++) m[r][c] = q[r];
    end
    q.delete();
    for (int k = 0; k < 5; k++) q.push_back(m[4-k][k]);
    q.sort();
    return 8'(q[2]);
  endfunction

  function automatic window_t rand_win();
    window_t    w;
    logic [7:0] mask;
    mask = ($urandom_range(1) == 1) ? 8'hff : 8'h0f;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[r][c] = 8'($urandom) & mask;
    return w;
  endfunction

  // Scoreboard
  logic [7:0]  exp_q [$];
  int unsigned hs_q  [$];
  logic        dir_en = 1'b0;
  logic [7:0]  dir_exp = '0;
  int unsigned last_hs = 0;
  bit          have_last = 1'b0;
  bit          cont_mode = 1'b0;
  int unsigned n_hs = 0;

  always @(negedge clk) begin
    if (rst_n && win_valid && win_ready) begin
      if (have_last) begin
        if (cont_mode) check("hs_period", longint'(cyc - last_hs), PERIOD);
        else           check("hs_spacing_min", longint'((cyc - last_hs) >= PERIOD), 1);
      end
      exp_q.push_back(dir_en ? dir_exp : ref_median(win));
      hs_q.push_back(cyc);
      last_hs   = cyc;
      have_last = 1'b1;
      n_hs++;
    end
  end

  logic [7:0] held = '0;
  bit         in_out = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_out = 1'b0;
    end else begin
      if (win_ready && busy) check("ready_while_busy", 1, 0);
      if (med_valid && !busy) check("valid_without_busy", 1, 0);
      if (!med_valid && in_out) begin
        check("valid_dropped_without_handshake", 1, 0);
        in_out = 1'b0;
      end
      if (med_valid) begin
        if (!in_out) begin
          in_out = 1'b1;
          held   = med;
          if (hs_q.size() == 0) check("spurious_valid", 1, 0);
          else                  check("latency", longint'(cyc - hs_q[0]), LAT);
        end else begin
          check("median_stable", med, held);
        end
        check("ready_low_in_out", win_ready, 0);
        if (med_ready) begin
          if (exp_q.size() > 0) begin
            check("median", med, exp_q.pop_front());
            void'(hs_q.pop_front());
          end
          in_out = 1'b0;
        end
      end
    end
  end

  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      med_ready = ($urandom_range(3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input window_t w, input bit directed, input logic [7:0] e);
    bit ok;
    ok        = 1'b0;
    dir_en    = directed;
    dir_exp   = e;
    win       = w;
    win_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = win_ready && rst_n;
      tick();
    end
    win_valid = 1'b0;
    if (!ok) check("handshake_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy;
    end
    if (!done) check("drain_timeout", 0, 1);
    tick();
  endtask

  window_t w;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_median", med, 0);
    check("reset_valid", med_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", win_ready, 1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", win_ready, 1);
    tick();

    // Directed windows
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) w[r][c] = 8'd7;
    send(w, 1'b1, 8'd7);
    drain();
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) w[r][c] = 8'(5 * r + c);
    send(w, 1'b1, 8'd12);
    drain();
    w = '0; w[2][2] = 8'd255;
    send(w, 1'b1, 8'd0);
    drain();
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) w[r][c] = 8'd255;
    w[2][2] = 8'd0;
    send(w, 1'b1, 8'd255);
    drain();

    // Five-cycle downstream stall in OUT
    med_ready = 1'b0;
    send(rand_win(), 1'b0, 8'd0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        seen = med_valid;
      end
      if (!seen) check("stall_valid_timeout", 0, 1);
    end
    repeat (4) @(negedge clk);
    tick();
    med_ready = 1'b1;
    drain();
`ifdef MEDIAN_KERNEL_SCHEDULER_PERF_CNT_EN
    check("perf_stall", perf_stall, 5);
    check("perf_windows_before_reset", perf_windows, 5);
`endif

    // Reset during the COL pass
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) w[r][c] = 8'd5;
    send(w, 1'b1, 8'd5);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midpass_reset_median", med, 0);
    check("midpass_reset_valid", med_valid, 0);
    check("midpass_reset_busy", busy, 0);
    exp_q.delete();
    hs_q.delete();
    have_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midpass_reset", win_ready, 1);
    tick();
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) w[r][c] = 8'd9;
    send(w, 1'b1, 8'd9);
    drain();
`ifdef MEDIAN_KERNEL_SCHEDULER_PERF_CNT_EN
    check("perf_windows_after_reset", perf_windows, 1);
`endif

    // Randomized windows with random downstream backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      send(rand_win(), 1'b0, 8'd0);
      repeat ($urandom_range(3)) tick();
    end
    rand_ready = 1'b0;
    tick();
    med_ready = 1'b1;
    drain();

    // Continuous valid with changing data
    have_last = 1'b0;
    cont_mode = 1'b1;
    dir_en    = 1'b0;
    begin
      int unsigned hs0;
      hs0       = n_hs;
      win_valid = 1'b1;
      for (int i = 0; i < 4 * PERIOD + 3; i++) begin
        win = rand_win();
        tick();
      end
      win_valid = 1'b0;
      check("continuous_accepts", longint'(n_hs - hs0), 5);
    end
    tick();
    cont_mode = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
